// File: rtl/count_ctrl.sv
`default_nettype none
// ============================================================================
//  count_ctrl - sweep controller for an external 4-bit up/down loadable counter
//  Optional ping-pong sweeps enabled by defining COUNT_CTRL_PINGPONG_EN.
//  Revision: 1.0
// ============================================================================
module count_ctrl #(
   parameter int PASSES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic       mode,
   input  logic [3:0] start_val,
   input  logic [3:0] end_val,
   input  logic [3:0] q,
   output logic       load,
   output logic       up,
   output logic [3:0] d,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e     state_q;
   logic [3:0] org_q;
   logic [3:0] tgt_q;
   logic       dir_q;
   logic       at_tgt;

`ifdef COUNT_CTRL_PINGPONG_EN
   localparam logic [3:0] C_PASSES = 4'(PASSES);
   logic       mode_q;
   logic [3:0] leg_q;
`else
   localparam int unused_passes = PASSES;
   logic       unused_mode;
   assign unused_mode = mode;
`endif

   assign at_tgt = (q == tgt_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         org_q   <= 4'd0;
         tgt_q   <= 4'd0;
         dir_q   <= 1'b0;
`ifdef COUNT_CTRL_PINGPONG_EN
         mode_q  <= 1'b0;
         leg_q   <= 4'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  org_q   <= start_val;
                  tgt_q   <= end_val;
                  dir_q   <= (end_val >= start_val);
`ifdef COUNT_CTRL_PINGPONG_EN
                  mode_q  <= mode;
                  leg_q   <= 4'd0;
`endif
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state_q <= abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
               // Abort takes priority over reaching the endpoint.
               if (abort) begin
                  state_q <= ST_IDLE;
               end else if (at_tgt) begin
`ifdef COUNT_CTRL_PINGPONG_EN
                  leg_q <= leg_q + 4'd1;
                  if (!mode_q || ((leg_q + 4'd1) == C_PASSES)) begin
                     state_q <= ST_DONE;
                  end else begin
                     org_q <= tgt_q;
                     tgt_q <= org_q;
                     dir_q <= ~dir_q;
                  end
`else
                  state_q <= ST_DONE;
`endif
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Outside LOAD and stepping RUN cycles the counter is told to reload itself.
   always_comb begin
      load = 1'b1;
      up   = 1'b0;
      d    = q;
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_LOAD: begin
            d    = org_q;
            up   = dir_q;
            busy = 1'b1;
         end
         ST_RUN: begin
            load = at_tgt;
            up   = dir_q;
            busy = 1'b1;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            load = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_count_ctrl.sv
`default_nettype none
// Randomized scoreboard bench: count_ctrl driving a 4-bit up/down loadable counter.
module tb_count_ctrl;

   localparam int PASSES = 4;

   typedef struct packed {
      logic [3:0] q;
      logic       load;
      logic       up;
      logic [3:0] d;
      logic       busy;
      logic       done;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       mode = 1'b0;
   logic [3:0] start_val = 4'd0;
   logic [3:0] end_val = 4'd0;
   logic [3:0] q;
   logic       load, up, busy, done;
   logic [3:0] d;

   exp_t       sb[$];
   exp_t       tr[$];
   exp_t       mon_e;
   logic [3:0] q_model = 4'd0;
   int         ab_eff;
   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   bit         mon_en = 1'b0;

   count_ctrl #(.PASSES(PASSES)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .start_val(start_val), .end_val(end_val), .q(q),
      .load(load), .up(up), .d(d), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Controlled counter
   always_ff @(posedge clk) begin
      if (reset)     q <= 4'd0;
      else if (load) q <= d;
      else if (up)   q <= q + 4'd1;
      else           q <= q - 4'd1;
   end

   function automatic exp_t idle_rec(input logic [3:0] v);
      return '{q: v, load: 1'b1, up: 1'b0, d: v, busy: 1'b0, done: 1'b0};
   endfunction

   function automatic exp_t run_rec(input int v, input bit ld, input bit dir);
      return '{q: 4'(v), load: ld, up: dir, d: 4'(v), busy: 1'b1, done: 1'b0};
   endfunction

   // Expected trace after the start edge: LOAD, then legs of values origin..target
   // (last value of each leg held), then DONE -- or an IDLE cycle after an abort.
   task automatic build(input logic [3:0] s, input logic [3:0] e, input bit pp, input int abort_k);
      exp_t       run[$];
      int         legs, org, tgt, v;
      bit         dir;
      logic [3:0] qa;
      tr.delete();
      ab_eff = -1;
      tr.push_back('{q: q_model, load: 1'b1, up: (e >= s), d: s, busy: 1'b1, done: 1'b0});
      legs = pp ? PASSES : 1;
      for (int leg = 0; leg < legs; leg++) begin
         org = (leg % 2 == 0) ? int'(s) : int'(e);
         tgt = (leg % 2 == 0) ? int'(e) : int'(s);
         dir = (e >= s) ^ (leg % 2 == 1);
         v = org;
         while (v != tgt) begin
            run.push_back(run_rec(v, 1'b0, dir));
            v = dir ? v + 1 : v - 1;
         end
         run.push_back(run_rec(tgt, 1'b1, dir));
      end
      if (abort_k >= 0 && abort_k < run.size()) begin
         ab_eff = abort_k;
         qa = (abort_k + 1 < run.size()) ? run[abort_k + 1].q : run[abort_k].q;
         for (int i = 0; i <= abort_k; i++) tr.push_back(run[i]);
         tr.push_back(idle_rec(qa));
      end else begin
         foreach (run[i]) tr.push_back(run[i]);
         qa = run[run.size() - 1].q;
         tr.push_back('{q: qa, load: 1'b1, up: 1'b0, d: qa, busy: 1'b0, done: 1'b1});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      tick();
      sb.push_back(idle_rec(q_model));
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Called with the current IDLE cycle's record already queued.
   task automatic sweep(input logic [3:0] s, input logic [3:0] e, input bit m,
                        input int abort_k, input int rst_k);
      bit pp;
      int L;
`ifdef COUNT_CTRL_PINGPONG_EN
      pp = m;
`else
      pp = 1'b0;
`endif
      build(s, e, pp, abort_k);
      if (rst_k >= 1 && rst_k < tr.size() && ab_eff < 0) begin
         while (tr.size() > rst_k) void'(tr.pop_back());
      end else begin
         rst_k = -1;
      end
      L = tr.size();
      foreach (tr[i]) sb.push_back(tr[i]);
      q_model = tr[L - 1].q;
      start = 1'b1; start_val = s; end_val = e; mode = m;
      for (int i = 1; i <= L; i++) begin
         tick();
         abort = (ab_eff >= 0 && i == ab_eff + 2);
         start = (tr[i - 1].busy || tr[i - 1].done) && ($urandom_range(0, 3) == 0);
         start_val = 4'($urandom); end_val = 4'($urandom); mode = 1'($urandom);
      end
      if (rst_k > 0) begin
         reset = 1'b1;
         start = 1'b1;
         tick();
         sb.push_back(idle_rec(4'd0));
         reset = 1'b0;
         start = 1'b0;
         q_model = 4'd0;
      end
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL underflow cycle %0d: DUT output with no expected entry", cyc);
            end else begin
               mon_e = sb.pop_front();
               if (q !== mon_e.q || load !== mon_e.load || up !== mon_e.up ||
                   busy !== mon_e.busy || done !== mon_e.done ||
                   (mon_e.load && d !== mon_e.d)) begin
                  miscompares++;
                  $display("FAIL outputs cycle %0d: got q=%0d load=%0b up=%0b d=%0d busy=%0b done=%0b, expected q=%0d load=%0b up=%0b d=%0d busy=%0b done=%0b",
                           cyc, q, load, up, d, busy, done,
                           mon_e.q, mon_e.load, mon_e.up, mon_e.d, mon_e.busy, mon_e.done);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int s, e, r, nrun, legs, k;
      bit m;
      reset = 1'b1;
      start = 1'b1;
      start_val = 4'd7; end_val = 4'd9;
      tick();
      sb.push_back(idle_rec(4'd0));
      mon_en = 1'b1;
      repeat (2) begin
         tick();
         sb.push_back(idle_rec(4'd0));
      end
      reset = 1'b0;
      start = 1'b0;
      idle();
      // Directed sweeps
      sweep(4'd3, 4'd9, 1'b0, -1, -1);   idle(); idle();
      sweep(4'd12, 4'd2, 1'b0, -1, -1);  idle(); idle();
      sweep(4'd5, 4'd5, 1'b0, -1, -1);   idle(); idle();
      sweep(4'd2, 4'd6, 1'b1, -1, -1);   idle(); idle();
      sweep(4'd5, 4'd5, 1'b1, -1, -1);   idle(); idle();
      sweep(4'd0, 4'd15, 1'b0, 7, -1);   idle(); idle();
      sweep(4'd4, 4'd11, 1'b0, -1, 4);   idle(); idle();
      sweep(4'd15, 4'd0, 1'b1, 0, -1);   idle();
      // Randomized sweeps
      for (int n = 0; n < 60; n++) begin
         s = int'($urandom_range(0, 15));
         e = int'($urandom_range(0, 15));
         m = 1'($urandom);
`ifdef COUNT_CTRL_PINGPONG_EN
         legs = m ? PASSES : 1;
`else
         legs = 1;
`endif
         nrun = legs * (((e >= s) ? e - s : s - e) + 1);
         r = int'($urandom_range(0, 9));
         if (r == 0) begin
            k = int'($urandom_range(0, nrun - 1));
            sweep(4'(s), 4'(e), m, k, -1);
         end else if (r == 1) begin
            k = int'($urandom_range(1, nrun + 1));
            sweep(4'(s), 4'(e), m, -1, k);
         end else begin
            sweep(4'(s), 4'(e), m, -1, -1);
         end
         repeat (1 + int'($urandom_range(0, 2))) idle();
      end
      idle();
      #2;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d expected entries left, expected 0", sb.size());
      end
      mon_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
